// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting interval timer, one-shot or auto-reload, level interrupt.
// Registers: CTRL {IE,AR,EN} @0x0, LOAD @0x4, COUNT @0x8, STATUS {EXP} @0xC (write-1-to-clear).
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic [31:0] addr,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        irq_o
);
   localparam int unsigned PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   logic          en_q, en_d, ar_q, ar_d, ie_q, ie_d, exp_q, exp_d;
   logic [31:0]   load_q, load_d, count_q, count_d, wmask;
   logic [PW-1:0] pre_q, pre_d;
   logic          hit, wr, tick, fire, ctrl_wr, load_wr, count_wr, clr;
   logic [1:0]    rsel;
   logic          unused_addr;

   assign hit         = ce && addr[31:4] == BASE_ADDR[31:4];
   assign wr          = hit && we;
   assign rsel        = addr[3:2];
   assign unused_addr = ^addr[1:0];
   assign wmask       = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   assign ctrl_wr     = wr && rsel == 2'd0 && sel[0];
   assign load_wr     = wr && rsel == 2'd1;
   assign count_wr    = wr && rsel == 2'd2 && |sel;
   assign clr         = wr && rsel == 2'd3 && sel[0] && data_i[0];
   assign tick        = en_q && pre_q == PRE_MAX;
   assign fire        = tick && count_q == '0;

   // A CPU write to COUNT overrides the tick, and a CTRL write overrides the one-shot stop.
   always_comb begin
      pre_d   = en_q ? (tick ? '0 : pre_q + PW'(1)) : '0;
      load_d  = load_wr ? (load_q & ~wmask) | (data_i & wmask) : load_q;
      count_d = count_wr ? (count_q & ~wmask) | (data_i & wmask)
              : fire ? (ar_q ? load_q : count_q)
              : tick ? count_q - 32'd1 : count_q;
      en_d    = ctrl_wr ? data_i[0] : en_q && !(fire && !ar_q);
      ar_d    = ctrl_wr ? data_i[1] : ar_q;
      ie_d    = ctrl_wr ? data_i[2] : ie_q;
      exp_d   = fire || (exp_q && !clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q   <= '0;
         load_q  <= '0;
         count_q <= '0;
         en_q    <= 1'b0;
         ar_q    <= 1'b0;
         ie_q    <= 1'b0;
         exp_q   <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         load_q  <= load_d;
         count_q <= count_d;
         en_q    <= en_d;
         ar_q    <= ar_d;
         ie_q    <= ie_d;
         exp_q   <= exp_d;
      end
   end

   assign irq_o  = exp_q && ie_q;
   assign data_o = !(hit && !we) ? '0
                 : rsel == 2'd0 ? {29'd0, ie_q, ar_q, en_q}
                 : rsel == 2'd1 ? load_q
                 : rsel == 2'd2 ? count_q
                 : {31'd0, exp_q};
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: vector table, directed corner sequences and random traffic against a behavioural model.
// Two timers share the bus: one with PRESCALE=1, one with PRESCALE=4.
module tb_mmio_timer;
   localparam bit [31:0] B = 32'h1000_0000;
   localparam bit [31:0] RC = B, RL = B + 32'h4, RN = B + 32'h8, RS = B + 32'hC;

   logic        clk, rst, ce, we;
   logic [3:0]  sel;
   logic [31:0] addr, data_i, data_o1, data_o4, rd1, rd4;
   logic        irq1, irq4;
   int          total = 0, bad = 0;

   mmio_timer #(.BASE_ADDR(B), .PRESCALE(1)) u_dut1 (
      .clk(clk), .rst(rst), .ce(ce), .we(we), .sel(sel), .addr(addr),
      .data_i(data_i), .data_o(data_o1), .irq_o(irq1));
   mmio_timer #(.BASE_ADDR(B), .PRESCALE(4)) u_dut4 (
      .clk(clk), .rst(rst), .ce(ce), .we(we), .sel(sel), .addr(addr),
      .data_i(data_i), .data_o(data_o4), .irq_o(irq4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Behavioural model: ticks happen every ps-th cycle of continuous enable.
   typedef struct {
      bit        en, ar, ie, exp;
      bit [31:0] load, count;
      int        elapsed;
   } mdl_t;
   mdl_t m1, m4;

   function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] d, input bit [3:0] s);
      bit [31:0] r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic bit [31:0] mread(input mdl_t m, input bit c, input bit w, input bit [31:0] a);
      if (!c || w || a[31:4] != B[31:4]) return 32'd0;
      case (a[3:2])
         2'd0:    return {29'd0, m.ie, m.ar, m.en};
         2'd1:    return m.load;
         2'd2:    return m.count;
         default: return {31'd0, m.exp};
      endcase
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input int ps, input bit r, input bit c, input bit w,
                                  input bit [3:0] s, input bit [31:0] a, input bit [31:0] d);
      mdl_t n;
      bit tick, fire, hw;
      n = m;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      tick = m.en && ((m.elapsed + 1) % ps == 0);
      fire = tick && m.count == 32'd0;
      hw = c && w && a[31:4] == B[31:4];
      n.elapsed = m.en ? m.elapsed + 1 : 0;
      if (fire) begin
         n.exp = 1'b1;
         if (m.ar) n.count = m.load;
         else n.en = 1'b0;
      end else if (tick) n.count = m.count - 32'd1;
      if (hw)
         case (a[3:2])
            2'd0: if (s[0]) {n.ie, n.ar, n.en} = d[2:0];
            2'd1: n.load = merge(m.load, d, s);
            2'd2: if (s != 4'd0) n.count = merge(m.count, d, s);
            default: if (s[0] && d[0] && !fire) n.exp = 1'b0;
         endcase
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One bus cycle: drive at negedge, sample read data mid-cycle, sample irq at the next negedge.
   task automatic bus(input bit r, input bit c, input bit w, input bit [3:0] s,
                      input bit [31:0] a, input bit [31:0] d);
      rst = r; ce = c; we = w; sel = s; addr = a; data_i = d;
      #1;
      rd1 = data_o1;
      rd4 = data_o4;
      chk("model_rd_p1", rd1, mread(m1, c, w, a));
      chk("model_rd_p4", rd4, mread(m4, c, w, a));
      @(posedge clk);
      m1 = mstep(m1, 1, r, c, w, s, a, d);
      m4 = mstep(m4, 4, r, c, w, s, a, d);
      @(negedge clk);
      chk("model_irq_p1", {31'd0, irq1}, {31'd0, m1.exp & m1.ie});
      chk("model_irq_p4", {31'd0, irq4}, {31'd0, m4.exp & m4.ie});
   endtask

   task automatic wr(input bit [31:0] a, input bit [31:0] d, input bit [3:0] s);
      bus(1'b0, 1'b1, 1'b1, s, a, d);
   endtask
   task automatic rdc(input bit [31:0] a, input bit [31:0] e, input string nm);
      bus(1'b0, 1'b1, 1'b0, 4'hF, a, 32'd0);
      chk(nm, rd1, e);
   endtask
   task automatic idle();
      bus(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
   endtask
   task automatic reset2();
      bus(1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
      bus(1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
   endtask
   task automatic irqc(input bit e, input string nm);
      chk(nm, {31'd0, irq1}, {31'd0, e});
   endtask

   typedef struct {
      bit        c, w;
      bit [3:0]  s;
      bit [31:0] a, d;
      bit        chk;
      bit [31:0] exp_d;
      bit        exp_irq;
      string     nm;
   } vec_t;
   vec_t tv[$];

   function automatic void add(input bit c, input bit w, input bit [3:0] s, input bit [31:0] a,
                               input bit [31:0] d, input bit ck, input bit [31:0] ed,
                               input bit ei, input string nm);
      vec_t v;
      v.c = c; v.w = w; v.s = s; v.a = a; v.d = d; v.chk = ck; v.exp_d = ed; v.exp_irq = ei; v.nm = nm;
      tv.push_back(v);
   endfunction
   function automatic void tw(input bit [31:0] a, input bit [31:0] d, input bit [3:0] s,
                              input bit ei, input string nm);
      add(1'b1, 1'b1, s, a, d, 1'b0, 32'd0, ei, nm);
   endfunction
   function automatic void trd(input bit [31:0] a, input bit [31:0] ed, input bit ei, input string nm);
      add(1'b1, 1'b0, 4'hF, a, 32'd0, 1'b1, ed, ei, nm);
   endfunction

   initial begin
      int k;
      rst = 1'b1; ce = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'd0; data_i = 32'd0;
      m1 = '{default: 0};
      m4 = '{default: 0};

      trd(RC, 32'd0, 1'b0, "rst_ctrl");
      trd(RL, 32'd0, 1'b0, "rst_load");
      trd(RN, 32'd0, 1'b0, "rst_count");
      trd(RS, 32'd0, 1'b0, "rst_status");
      tw(RL, 32'd3, 4'hF, 1'b0, "ar_wload");
      tw(RN, 32'd3, 4'hF, 1'b0, "ar_wcount");
      tw(RC, 32'd7, 4'hF, 1'b0, "ar_wctrl");
      trd(RN, 32'd3, 1'b0, "ar_cnt3");
      trd(RN, 32'd2, 1'b0, "ar_cnt2");
      trd(RN, 32'd1, 1'b0, "ar_cnt1");
      trd(RN, 32'd0, 1'b1, "ar_cnt0");
      trd(RN, 32'd3, 1'b1, "ar_reload");
      trd(RS, 32'd1, 1'b1, "ar_exp1");
      tw(RS, 32'd1, 4'hF, 1'b0, "ar_w1c");
      trd(RS, 32'd0, 1'b1, "ar_exp_clr");
      trd(RS, 32'd1, 1'b1, "ar_exp_again");
      tw(RC, 32'd0, 4'hF, 1'b0, "ar_stop");
      trd(RN, 32'd1, 1'b0, "ar_frozen_a");
      trd(RN, 32'd1, 1'b0, "ar_frozen_b");
      tw(RS, 32'd1, 4'hF, 1'b0, "ar_w1c2");
      trd(RS, 32'd0, 1'b0, "ar_status0");
      tw(RN, 32'd0, 4'hF, 1'b0, "be_zero");
      tw(RN, 32'hAABBCCDD, 4'b0101, 1'b0, "be_write");
      trd(RN, 32'h00BB00DD, 1'b0, "be_count");
      add(1'b1, 1'b0, 4'h0, RN, 32'd0, 1'b1, 32'h00BB00DD, 1'b0, "rd_sel0");
      trd(B + 32'h10, 32'd0, 1'b0, "dec_rd_out");
      tw(B + 32'h18, 32'd5, 4'hF, 1'b0, "dec_wr_out");
      trd(RN, 32'h00BB00DD, 1'b0, "dec_count_kept");
      add(1'b0, 1'b0, 4'hF, RN, 32'd0, 1'b1, 32'd0, 1'b0, "dec_ce0");
      tw(RL, 32'h55, 4'hF, 1'b0, "ld_write");
      trd(RN, 32'h00BB00DD, 1'b0, "ld_no_count");
      trd(RL, 32'h55, 1'b0, "ld_read");
      tw(RC, 32'hFFFF_FFFE, 4'hF, 1'b0, "ctrl_wide");
      trd(RC, 32'd6, 1'b0, "ctrl_bits");
      tw(B + 32'hB, 32'h12, 4'hF, 1'b0, "low_addr_wr");
      trd(RN, 32'h12, 1'b0, "low_addr_rd");
      trd(RS, 32'd0, 1'b0, "final_status");

      @(negedge clk);
      reset2();
      for (int i = 0; i < tv.size(); i++) begin
         bus(1'b0, tv[i].c, tv[i].w, tv[i].s, tv[i].a, tv[i].d);
         if (tv[i].chk) chk(tv[i].nm, rd1, tv[i].exp_d);
         chk({tv[i].nm, "_irq"}, {31'd0, irq1}, {31'd0, tv[i].exp_irq});
      end

      // One-shot expiry and stop
      reset2();
      wr(RN, 32'd2, 4'hF);
      wr(RC, 32'd5, 4'hF);
      idle(); idle();
      irqc(1'b0, "os_irq_early");
      idle();
      irqc(1'b1, "os_irq");
      rdc(RS, 32'd1, "os_exp");
      rdc(RC, 32'd4, "os_ctrl");
      rdc(RN, 32'd0, "os_count");
      idle(); idle(); idle();
      rdc(RN, 32'd0, "os_count_stays");
      wr(RS, 32'd1, 4'hF);
      irqc(1'b0, "os_irq_clr");
      rdc(RS, 32'd0, "os_status_clr");

      // W1C on the expiry cycle: set wins
      reset2();
      wr(RN, 32'd1, 4'hF);
      wr(RC, 32'd5, 4'hF);
      idle();
      wr(RS, 32'd1, 4'hF);
      irqc(1'b1, "col_w1c_irq");
      rdc(RS, 32'd1, "col_w1c_exp");

      // COUNT write on a tick cycle wins
      reset2();
      wr(RN, 32'd5, 4'hF);
      wr(RC, 32'd1, 4'hF);
      wr(RN, 32'd9, 4'hF);
      rdc(RN, 32'd9, "col_count_wr");

      // CTRL write on a one-shot expiry cycle wins
      reset2();
      wr(RN, 32'd0, 4'hF);
      wr(RC, 32'd1, 4'hF);
      wr(RC, 32'd3, 4'hF);
      rdc(RC, 32'd3, "col_ctrl_wr");

      // Partial COUNT write during a tick keeps the pre-edge upper bytes
      reset2();
      wr(RN, 32'h100, 4'hF);
      wr(RC, 32'd1, 4'hF);
      wr(RN, 32'h55, 4'b0001);
      rdc(RN, 32'h155, "col_partial");

      // Reset while expired drops irq
      reset2();
      wr(RN, 32'd0, 4'hF);
      wr(RC, 32'd5, 4'hF);
      idle();
      irqc(1'b1, "rst_mid_irq_before");
      bus(1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
      irqc(1'b0, "rst_mid_irq_after");
      rdc(RC, 32'd0, "rst_mid_ctrl");

      // PRESCALE=4: COUNT=1 expires 8 cycles after enable
      reset2();
      wr(RN, 32'd1, 4'hF);
      wr(RC, 32'd1, 4'hF);
      k = 0;
      for (int j = 1; j <= 20 && k == 0; j++) begin
         bus(1'b0, 1'b1, 1'b0, 4'hF, RS, 32'd0);
         if (rd4[0]) k = j;
      end
      chk("pre4_latency", 32'(k), 32'd9);

      // Random traffic against the model
      reset2();
      for (int i = 0; i < 3000; i++) begin
         bit [31:0] a, d;
         bit [3:0]  s;
         bit        r, c, w;
         a = B | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = a + (32'($urandom_range(1, 4)) << 4);
         d = $urandom;
         if ($urandom_range(0, 3) != 0) d = d & 32'h1F;
         s = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 199) == 0;
         c = $urandom_range(0, 9) != 0;
         w = $urandom_range(0, 1) == 1;
         bus(r, c, w, s, a, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
